// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command issuer: holds one abstract command, enforces per-bank state and
// command spacing, then drives the registered DDR4 command/address pins.
// Optional CA parity is enabled with the CA_PARITY_EN macro.
module ddr4_cmd_issuer #(
  parameter int TRCD = 4,
  parameter int TRP  = 4,
  parameter int TRAS = 10,
  parameter int TRFC = 20,
  parameter int TCCD = 4,
  parameter int TMOD = 8,
  parameter int TXP  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_adr,
  output logic        err,
  output logic        busy,
  output logic        act_n,
  output logic [16:0] adr,
  output logic [1:0]  ba,
  output logic [1:0]  bg,
  output logic        cs_n,
  output logic        cke,
  output logic        par,
  output logic        reset_n
);

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ACT  = 4'd1,
    C_RD   = 4'd2,
    C_RDA  = 4'd3,
    C_WR   = 4'd4,
    C_WRA  = 4'd5,
    C_PR   = 4'd6,
    C_PRA  = 4'd7,
    C_REF  = 4'd8,
    C_MRW  = 4'd9,
    C_CKEL = 4'd10,
    C_CKEH = 4'd11
  } cmd_e;

  // A spacing of T cycles loads T-1; 0 or 1 means no wait at all.
  function automatic logic [7:0] f_load(input int t);
    if (t > 1) return 8'(t - 1);
    return '0;
  endfunction

  // Hold register
  logic        r_hold_valid;
  logic [3:0]  r_cmd;
  logic [1:0]  r_bg;
  logic [1:0]  r_ba;
  logic [16:0] r_adr;

  // Bank state and timers
  logic [15:0] r_open;
  logic [7:0]  r_act_t [16];
  logic [7:0]  r_col_t [16];
  logic [7:0]  r_pre_t [16];
  logic [7:0]  r_ccd_t;
  logic [7:0]  r_rfc_t;
  logic [7:0]  r_mod_t;
  logic [7:0]  r_xp_t;

  // Pin registers
  logic        r_cs_n;
  logic        r_act_n;
  logic [16:0] r_pin_adr;
  logic [1:0]  r_pin_bg;
  logic [1:0]  r_pin_ba;
  logic        r_cke;
  logic        r_err;
  logic        r_reset_n;

  logic [3:0]  w_bank;
  logic [15:0] w_hit;
  logic        w_bank_open;
  logic        w_any_open;
  logic        w_gate;
  logic        w_act_idle;
  logic        w_pra_ok;
  logic        w_issue;
  logic        w_err;
  logic        w_drop;
  logic        w_consume;
  logic        w_close;
  logic        w_cs_n;
  logic        w_act_n;
  logic [16:0] w_adr;
  logic [1:0]  w_bg;
  logic [1:0]  w_ba;

  assign w_bank      = {r_bg, r_ba};
  assign w_hit       = 16'd1 << w_bank;
  assign w_bank_open = r_open[w_bank];
  assign w_any_open  = |r_open;
  assign w_gate      = (r_rfc_t == '0) && (r_mod_t == '0) && (r_xp_t == '0);
  assign w_consume   = w_issue | w_err | w_drop;
  assign w_close     = (r_cmd == C_PR) || (r_cmd == C_RDA) || (r_cmd == C_WRA);

  assign req_ready = r_reset_n & (~r_hold_valid | w_consume);
  assign busy      = r_hold_valid | ~w_gate;
  assign err       = r_err;
  assign cs_n      = r_cs_n;
  assign act_n     = r_act_n;
  assign adr       = r_pin_adr;
  assign bg        = r_pin_bg;
  assign ba        = r_pin_ba;
  assign cke       = r_cke;
  assign reset_n   = r_reset_n;

  // Scan all banks for outstanding ACT spacing and precharge readiness.
  always_comb begin
    w_act_idle = 1'b1;
    w_pra_ok   = 1'b1;
    for (int unsigned b = 0; b < 16; b++) begin
      if (r_act_t[b] != '0) w_act_idle = 1'b0;
      if (r_open[b] && (r_pre_t[b] != '0)) w_pra_ok = 1'b0;
    end
  end

  // Decide whether the held command issues, errors out, or keeps waiting.
  // Protocol violations are flagged before any timer wait; CKE low stalls all but CKEH.
  always_comb begin
    w_issue = 1'b0;
    w_err   = 1'b0;
    w_drop  = 1'b0;
    if (r_hold_valid) begin
      if (r_cmd == C_NOP) begin
        w_drop = 1'b1;
      end else if (r_cke || (r_cmd == C_CKEH)) begin
        case (r_cmd)
          C_ACT:
            if (w_bank_open) w_err = 1'b1;
            else w_issue = w_gate && (r_act_t[w_bank] == '0);
          C_RD, C_RDA, C_WR, C_WRA:
            if (!w_bank_open) w_err = 1'b1;
            else w_issue = w_gate && (r_col_t[w_bank] == '0) && (r_ccd_t == '0);
          C_PR:
            if (!w_bank_open) w_err = 1'b1;
            else w_issue = w_gate && (r_pre_t[w_bank] == '0);
          C_PRA:
            w_issue = w_gate && w_pra_ok;
          C_REF, C_MRW:
            if (w_any_open) w_err = 1'b1;
            else w_issue = w_gate && w_act_idle;
          C_CKEL, C_CKEH:
            w_issue = w_gate;
          default:
            w_err = 1'b1;
        endcase
      end
    end
  end

  // Encode the issuing command onto the pin values; DES otherwise.
  always_comb begin
    w_cs_n  = 1'b1;
    w_act_n = 1'b1;
    w_adr   = '0;
    w_bg    = '0;
    w_ba    = '0;
    if (w_issue) begin
      case (r_cmd)
        C_ACT: begin
          w_cs_n  = 1'b0;
          w_act_n = 1'b0;
          w_adr   = r_adr;
          w_bg    = r_bg;
          w_ba    = r_ba;
        end
        C_RD, C_RDA, C_WR, C_WRA: begin
          w_cs_n       = 1'b0;
          w_adr[16:14] = ((r_cmd == C_RD) || (r_cmd == C_RDA)) ? 3'b101 : 3'b100;
          w_adr[10]    = (r_cmd == C_RDA) || (r_cmd == C_WRA);
          w_adr[9:0]   = r_adr[9:0];
          w_bg         = r_bg;
          w_ba         = r_ba;
        end
        C_PR: begin
          w_cs_n       = 1'b0;
          w_adr[16:14] = 3'b010;
          w_bg         = r_bg;
          w_ba         = r_ba;
        end
        C_PRA: begin
          w_cs_n       = 1'b0;
          w_adr[16:14] = 3'b010;
          w_adr[10]    = 1'b1;
        end
        C_REF: begin
          w_cs_n       = 1'b0;
          w_adr[16:14] = 3'b001;
        end
        C_MRW: begin
          w_cs_n       = 1'b0;
          w_adr[13:0]  = r_adr[13:0];
          w_bg         = r_bg;
          w_ba         = r_ba;
        end
        default: ;
      endcase
    end
  end

  // Hold register: load on handshake, free when the held command is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_cmd        <= '0;
      r_bg         <= '0;
      r_ba         <= '0;
      r_adr        <= '0;
    end else if (req_valid && req_ready) begin
      r_hold_valid <= 1'b1;
      r_cmd        <= req_cmd;
      r_bg         <= req_bg;
      r_ba         <= req_ba;
      r_adr        <= req_adr;
    end else if (w_consume) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Per-bank state and timers: load on issue, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_open <= '0;
      for (int unsigned b = 0; b < 16; b++) begin
        r_act_t[b] <= '0;
        r_col_t[b] <= '0;
        r_pre_t[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 16; b++) begin
        if (w_issue && (r_cmd == C_ACT) && w_hit[b]) begin
          r_col_t[b] <= f_load(TRCD);
          r_pre_t[b] <= f_load(TRAS);
          r_open[b]  <= 1'b1;
        end else begin
          r_col_t[b] <= (r_col_t[b] != '0) ? r_col_t[b] - 8'd1 : '0;
          r_pre_t[b] <= (r_pre_t[b] != '0) ? r_pre_t[b] - 8'd1 : '0;
        end
        if (w_issue && ((w_close && w_hit[b]) || ((r_cmd == C_PRA) && r_open[b]))) begin
          r_act_t[b] <= f_load(TRP);
          r_open[b]  <= 1'b0;
        end else begin
          r_act_t[b] <= (r_act_t[b] != '0) ? r_act_t[b] - 8'd1 : '0;
        end
      end
    end
  end

  // Global timers: column spacing, refresh, mode register and power-down exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ccd_t <= '0;
      r_rfc_t <= '0;
      r_mod_t <= '0;
      r_xp_t  <= '0;
    end else begin
      if (w_issue && (r_cmd inside {C_RD, C_RDA, C_WR, C_WRA})) r_ccd_t <= f_load(TCCD);
      else r_ccd_t <= (r_ccd_t != '0) ? r_ccd_t - 8'd1 : '0;
      if (w_issue && (r_cmd == C_REF)) r_rfc_t <= f_load(TRFC);
      else r_rfc_t <= (r_rfc_t != '0) ? r_rfc_t - 8'd1 : '0;
      if (w_issue && (r_cmd == C_MRW)) r_mod_t <= f_load(TMOD);
      else r_mod_t <= (r_mod_t != '0) ? r_mod_t - 8'd1 : '0;
      if (w_issue && (r_cmd == C_CKEH)) r_xp_t <= f_load(TXP);
      else r_xp_t <= (r_xp_t != '0) ? r_xp_t - 8'd1 : '0;
    end
  end

  // Registered pins: one cycle of command, then back to DES.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n    <= 1'b1;
      r_act_n   <= 1'b1;
      r_pin_adr <= '0;
      r_pin_bg  <= '0;
      r_pin_ba  <= '0;
      r_cke     <= 1'b0;
      r_err     <= 1'b0;
      r_reset_n <= 1'b0;
    end else begin
      r_cs_n    <= w_cs_n;
      r_act_n   <= w_act_n;
      r_pin_adr <= w_adr;
      r_pin_bg  <= w_bg;
      r_pin_ba  <= w_ba;
      r_err     <= w_err;
      r_reset_n <= 1'b1;
      if (w_issue && (r_cmd == C_CKEL)) r_cke <= 1'b0;
      else if (w_issue && (r_cmd == C_CKEH)) r_cke <= 1'b1;
    end
  end

`ifdef CA_PARITY_EN
  logic r_par;
  assign par = r_par;

  // Even CA parity registered alongside the command; zero during DES.
  always_ff @(posedge clk) begin
    if (rst) r_par <= 1'b0;
    else r_par <= ~w_cs_n & (^{w_act_n, w_adr, w_bg, w_ba});
  end
`else
  assign par = 1'b0;
`endif

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Directed bench for ddr4_cmd_issuer with a scoreboard of expected pin events.
module tb_ddr4_cmd_issuer;
  localparam int TRCD = 4;
  localparam int TRP  = 4;
  localparam int TRAS = 10;
  localparam int TRFC = 20;
  localparam int TCCD = 4;
  localparam int TMOD = 8;
  localparam int TXP  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = '0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_adr = '0;
  logic        err, busy, act_n, cs_n, cke, par, reset_n;
  logic [16:0] adr;
  logic [1:0]  ba, bg;

  ddr4_cmd_issuer #(
    .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC),
    .TCCD(TCCD), .TMOD(TMOD), .TXP(TXP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bg(req_bg), .req_ba(req_ba), .req_adr(req_adr),
    .err(err), .busy(busy), .act_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .cs_n(cs_n), .cke(cke), .par(par), .reset_n(reset_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic        act_n;
    logic [16:0] adr;
    logic [1:0]  bg;
    logic [1:0]  ba;
  } exp_t;

  exp_t sb[$];
  int   ev_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   cke_rise = -1;
  logic cke_q = 1'b0;
  int   acc;

  function automatic logic exp_par(exp_t e);
`ifdef CA_PARITY_EN
    return ^{e.act_n, e.adr, e.bg, e.ba};
`else
    return 1'b0 & e.act_n;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any pin event seen there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (cke === 1'b1 && cke_q === 1'b0) cke_rise = cyc;
    cke_q = cke;
    if (err === 1'b1 || cs_n === 1'b0) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=err%0b/cs_n%0b expected=no event", err, cs_n);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ev_cyc.push_back(cyc);
        if (e.is_err) begin
          chk("err_pins", 32'({err, cs_n}), 32'(2'b11));
        end else begin
          chk("cmd_pins", 32'({err, cs_n, act_n, bg, ba, adr}),
              32'({1'b0, 1'b0, e.act_n, e.bg, e.ba, e.adr}));
          chk("par", 32'(par), 32'(exp_par(e)));
        end
      end
    end
  endtask

  task automatic expect_cmd(input logic an, input logic [16:0] a, input logic [1:0] g, input logic [1:0] b);
    exp_t e;
    e.is_err = 1'b0; e.act_n = an; e.adr = a; e.bg = g; e.ba = b;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.act_n = 1'b1; e.adr = '0; e.bg = '0; e.ba = '0;
    sb.push_back(e);
  endtask

  // Present one request and hold it until the handshake completes.
  task automatic send(input logic [3:0] c, input logic [1:0] g, input logic [1:0] b,
                      input logic [16:0] a, output int acc_cyc);
    bit done = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_cmd = c; req_bg = g; req_ba = b; req_adr = a;
    while (!done && n < 200) begin
      #1;
      done = req_ready;
      step();
      n++;
    end
    chk("handshake", 32'(done), 32'd1);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_reset_n", 32'(reset_n), 32'd0);
    chk("rst_pins", 32'({cs_n, act_n, adr, ba, bg, cke, par, err, busy}),
        32'({1'b1, 1'b1, 17'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;
    step();
    chk("post_rst_reset_n", 32'(reset_n), 32'd1);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Power-up CKEH and exit-latency busy window
    send(4'd11, 2'd0, 2'd0, 17'd0, acc);
    chk("ckeh_pending_cke", 32'(cke), 32'd0);
    chk("ckeh_pending_busy", 32'(busy), 32'd1);
    step();
    chk("ckeh_cke", 32'(cke), 32'd1);
    chk("txp_busy1", 32'(busy), 32'd1);
    step();
    chk("txp_busy2", 32'(busy), 32'd1);
    step();
    chk("txp_busy_done", 32'(busy), 32'd0);

    send(4'd10, 2'd0, 2'd0, 17'd0, acc);
    step();
    chk("ckel_cke", 32'(cke), 32'd0);

    // CKEH then ACT (waits tXP) then RD (waits tRCD)
    send(4'd11, 2'd0, 2'd0, 17'd0, acc);
    expect_cmd(1'b0, 17'h01234, 2'd1, 2'd2);
    send(4'd1, 2'd1, 2'd2, 17'h01234, acc);
    expect_cmd(1'b1, 17'h14008, 2'd1, 2'd2);
    send(4'd2, 2'd1, 2'd2, 17'h00008, acc);

    // ACT bank 0, PR (tRAS), ACT again (tRP)
    expect_cmd(1'b0, 17'h00001, 2'd0, 2'd0);
    send(4'd1, 2'd0, 2'd0, 17'h00001, acc);
    expect_cmd(1'b1, 17'h08000, 2'd0, 2'd0);
    send(4'd6, 2'd0, 2'd0, 17'd0, acc);
    expect_cmd(1'b0, 17'h00003, 2'd0, 2'd0);
    send(4'd1, 2'd0, 2'd0, 17'h00003, acc);

    // Protocol errors: RD to closed bank 5, illegal code 14
    expect_err();
    send(4'd2, 2'd1, 2'd1, 17'h00008, acc);
    step();
    chk("err_rd_ready", 32'(req_ready), 32'd1);
    expect_err();
    send(4'd14, 2'd0, 2'd0, 17'd0, acc);
    step();
    chk("err_ill_ready", 32'(req_ready), 32'd1);

    // ACT bank 3, REF while open (err), PRA, REF, ACT after tRFC
    expect_cmd(1'b0, 17'h00055, 2'd0, 2'd3);
    send(4'd1, 2'd0, 2'd3, 17'h00055, acc);
    expect_err();
    send(4'd8, 2'd0, 2'd0, 17'd0, acc);
    expect_cmd(1'b1, 17'h08400, 2'd0, 2'd0);
    send(4'd7, 2'd0, 2'd0, 17'd0, acc);
    expect_cmd(1'b1, 17'h04000, 2'd0, 2'd0);
    send(4'd8, 2'd0, 2'd0, 17'd0, acc);
    expect_cmd(1'b0, 17'h00077, 2'd0, 2'd3);
    send(4'd1, 2'd0, 2'd3, 17'h00077, acc);

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    repeat (5) step();
    chk("drain", 32'(sb.size()), 32'd0);
    chk("ev_count", 32'(ev_cyc.size()), 32'd12);
    if (ev_cyc.size() == 12) begin
      chk("tXP_ckeh_to_act", 32'(ev_cyc[0] - cke_rise), 32'(TXP));
      chk("tRCD_act_to_rd", 32'(ev_cyc[1] - ev_cyc[0]), 32'(TRCD));
      chk("tRAS_act_to_pr", 32'(ev_cyc[3] - ev_cyc[2]), 32'(TRAS));
      chk("tRP_pr_to_act", 32'(ev_cyc[4] - ev_cyc[3]), 32'(TRP));
      chk("tRP_pra_to_ref", 32'(ev_cyc[10] - ev_cyc[9]), 32'(TRP));
      chk("tRFC_ref_to_act", 32'(ev_cyc[11] - ev_cyc[10]), 32'(TRFC));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
